// File: rtl/cnn_pkg.sv
// cnn_pkg: scheduler state encoding and default layer parameters.
package cnn_pkg;
   localparam int MAX_FILTERS_DEF    = 16;
   localparam int WEIGHT_LAT_DEF     = 2;
   localparam int TIMEOUT_CYCLES_DEF = 1048576;
   localparam int CNT_W_DEF          = 21;
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DRAIN, FIN, ERROR} sched_state_e;
endpackage

// File: rtl/sched_run_timer.sv
// sched_run_timer: RUN cycle counter with timeout compare and capture-on-done.
module sched_run_timer
   import cnn_pkg::*;
#(
   parameter int CNT_W          = CNT_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_ni,
   input  logic             en_i,
   input  logic             done_i,
   output logic             timeout_o,
   output logic [CNT_W-1:0] cycles_o
);
   logic [CNT_W-1:0] cnt_q, cycles_q;
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q    <= '0;
         cycles_q <= '0;
      end else begin
         cnt_q <= !clr_ni ? '0 : en_i ? cnt_q + CNT_W'(1) : cnt_q;
         if (en_i && done_i) cycles_q <= cnt_q + CNT_W'(1);
      end
   end
   assign timeout_o = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
   assign cycles_o  = cycles_q;
endmodule

// File: rtl/cnn_layer_scheduler.sv
// cnn_layer_scheduler: sequences the conv+maxpool accelerator over a bank of filters.
module cnn_layer_scheduler
   import cnn_pkg::*;
#(
   parameter int MAX_FILTERS    = MAX_FILTERS_DEF,
   parameter int FILT_W         = $clog2(MAX_FILTERS),
   parameter int WEIGHT_LAT     = WEIGHT_LAT_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [FILT_W:0]   num_filters,
   output logic [FILT_W-1:0] weight_sel,
   output logic              acc_clear,
   output logic              acc_en,
   input  logic              acc_done,
   output logic              wr_valid,
   output logic [FILT_W-1:0] wr_chan,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  run_cycles
);
   localparam int LW = $clog2(WEIGHT_LAT) + 1;
   sched_state_e      state_q, state_d;
   logic [FILT_W-1:0] idx_q, idx_d;
   logic [FILT_W:0]   num_q, num_d;
   logic [LW-1:0]     lat_q, lat_d;
   logic              timeout, start_ok, in_run;
   logic              acc_clear_q, acc_en_q, wr_valid_q, busy_q, done_q, error_q;
   logic [FILT_W-1:0] weight_sel_q, wr_chan_q;
   assign start_ok = num_filters != '0 && num_filters <= (FILT_W+1)'(MAX_FILTERS);
   assign in_run   = state_q == RUN;
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      num_d   = num_q;
      lat_d   = lat_q;
      if (abort) state_d = IDLE;
      else begin
         unique case (state_q)
            IDLE, ERROR: if (start) begin
               num_d   = num_filters;
               idx_d   = '0;
               state_d = start_ok ? CLEAR : FIN;
            end
            CLEAR: begin
               lat_d   = LW'(WEIGHT_LAT - 1);
               state_d = LOAD;
            end
            LOAD: if (lat_q == '0) state_d = RUN; else lat_d = lat_q - LW'(1);
            RUN: state_d = acc_done ? DRAIN : timeout ? ERROR : RUN;
            DRAIN: if (wr_ready) begin
               if ({1'b0, idx_q} == num_q - (FILT_W+1)'(1)) state_d = FIN;
               else begin
                  idx_d   = idx_q + FILT_W'(1);
                  state_d = CLEAR;
               end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end
   // Outputs are decoded from the next state so each one is a plain register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         num_q        <= '0;
         lat_q        <= '0;
         acc_clear_q  <= 1'b0;
         acc_en_q     <= 1'b0;
         wr_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         weight_sel_q <= '0;
         wr_chan_q    <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         num_q        <= num_d;
         lat_q        <= lat_d;
         acc_clear_q  <= state_d == CLEAR || (abort && (state_q == RUN || state_q == DRAIN));
         acc_en_q     <= state_d == RUN;
         wr_valid_q   <= state_d == DRAIN;
         busy_q       <= state_d inside {CLEAR, LOAD, RUN, DRAIN};
         done_q       <= state_d == FIN;
         error_q      <= state_d == ERROR;
         weight_sel_q <= idx_d;
         wr_chan_q    <= idx_d;
      end
   end
   sched_run_timer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clr_ni    (in_run),
      .en_i      (in_run),
      .done_i    (acc_done && !abort),
      .timeout_o (timeout),
      .cycles_o  (run_cycles)
   );
   assign weight_sel = weight_sel_q;
   assign acc_clear  = acc_clear_q;
   assign acc_en     = acc_en_q;
   assign wr_valid   = wr_valid_q;
   assign wr_chan    = wr_chan_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
endmodule
